// File: rtl/segment_pkg.sv
// segment_pkg: motion record layout, MotionSegment type and state-byte codes.
package segment_pkg;
  localparam int MOTORS = 8;
  localparam int MAX_MOVE_STEP_BITS = 16;
  localparam int AUX_BITS = 16;
  localparam int REG_BITS = 2 * MAX_MOVE_STEP_BITS;
  localparam logic [7:0] STATE_EMPTY = 8'd0;
  localparam logic [7:0] STATE_FILLED = 8'd1;
  localparam logic [7:0] STATE_EXIT = 8'd2;
  // Declared MSB-first so that direction_bits lands on the LSBs, matching the record order.
  typedef struct packed {
    logic [MOTORS-1:0][REG_BITS-1:0] fractions;
    logic [REG_BITS-1:0] travel_delay_cycles;
    logic [REG_BITS-1:0] hires_accel_cycles;
    logic [REG_BITS-1:0] accel_series_index;
    logic [AUX_BITS-1:0] aux;
    logic [MAX_MOVE_STEP_BITS-1:0] loops_decel;
    logic [MAX_MOVE_STEP_BITS-1:0] loops_travel;
    logic [MAX_MOVE_STEP_BITS-1:0] loops_accel;
    logic [MOTORS-1:0] direction_bits;
  } motion_segment_t;
  localparam int SEG_W = $bits(motion_segment_t);
  localparam int OFF_STATE = 0;
  localparam int OFF_DIR = 8;
  localparam int OFF_LOOPS_ACCEL = OFF_DIR + MOTORS;
  localparam int OFF_LOOPS_TRAVEL = OFF_LOOPS_ACCEL + MAX_MOVE_STEP_BITS;
  localparam int OFF_LOOPS_DECEL = OFF_LOOPS_TRAVEL + MAX_MOVE_STEP_BITS;
  localparam int OFF_AUX = OFF_LOOPS_DECEL + MAX_MOVE_STEP_BITS;
  localparam int OFF_ACCEL_IDX = OFF_AUX + AUX_BITS;
  localparam int OFF_HIRES = OFF_ACCEL_IDX + REG_BITS;
  localparam int OFF_TRAVEL_DELAY = OFF_HIRES + REG_BITS;
  localparam int OFF_FRAC = OFF_TRAVEL_DELAY + REG_BITS;
  function automatic int record_bytes(input int motors, input int step_bits, input int aux_bits);
    return (8 + motors + 3 * step_bits + aux_bits + (3 + motors) * 2 * step_bits + 7) / 8;
  endfunction
endpackage

// File: rtl/segment_unpack.sv
// segment_unpack: slices a packed motion record into its state byte and MotionSegment.
module segment_unpack
  import segment_pkg::*;
#(
  parameter int REC_W = 432
) (
  input  logic [REC_W-1:0] record_i,
  output logic [7:0]       state_o,
  output motion_segment_t  seg_o
);
  assign state_o = record_i[OFF_STATE +: 8];
  assign seg_o.direction_bits = record_i[OFF_DIR +: MOTORS];
  assign seg_o.loops_accel = record_i[OFF_LOOPS_ACCEL +: MAX_MOVE_STEP_BITS];
  assign seg_o.loops_travel = record_i[OFF_LOOPS_TRAVEL +: MAX_MOVE_STEP_BITS];
  assign seg_o.loops_decel = record_i[OFF_LOOPS_DECEL +: MAX_MOVE_STEP_BITS];
  assign seg_o.aux = record_i[OFF_AUX +: AUX_BITS];
  assign seg_o.accel_series_index = record_i[OFF_ACCEL_IDX +: REG_BITS];
  assign seg_o.hires_accel_cycles = record_i[OFF_HIRES +: REG_BITS];
  assign seg_o.travel_delay_cycles = record_i[OFF_TRAVEL_DELAY +: REG_BITS];
  for (genvar m = 0; m < MOTORS; m++) begin : g_frac
    assign seg_o.fractions[m] = record_i[OFF_FRAC + m * REG_BITS +: REG_BITS];
  end
endmodule

// File: rtl/segment_sequencer.sv
// segment_sequencer: pulls motion records from the Fifo, decodes them and offers
// segments to the StepEngine over valid/ready, tracking completion and error flags.
module segment_sequencer #(
  parameter int MOTORS = segment_pkg::MOTORS,
  parameter int MAX_MOVE_STEP_BITS = segment_pkg::MAX_MOVE_STEP_BITS,
  parameter int AUX_BITS = segment_pkg::AUX_BITS,
  parameter int RECORD_SIZE_BYTES = 54
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable_i,
  input  logic                              abort_i,
  input  logic                              fifo_available_i,
  output logic                              fifo_request_o,
  input  logic                              fifo_record_ready_i,
  input  logic [RECORD_SIZE_BYTES*8-1:0]    fifo_record_i,
  output logic                              seg_valid_o,
  input  logic                              seg_ready_i,
  output logic [segment_pkg::SEG_W-1:0]     seg_data_o,
  input  logic                              engine_busy_i,
  output logic                              finished_o,
  output logic                              underrun_o,
  output logic                              protocol_error_o,
  output logic [31:0]                       segments_done_o
);
  import segment_pkg::*;
  if (RECORD_SIZE_BYTES < record_bytes(MOTORS, MAX_MOVE_STEP_BITS, AUX_BITS)) begin : g_size_err
    $error("RECORD_SIZE_BYTES is too small for the motion record layout");
  end
  if (MOTORS != segment_pkg::MOTORS || MAX_MOVE_STEP_BITS != segment_pkg::MAX_MOVE_STEP_BITS ||
      AUX_BITS != segment_pkg::AUX_BITS) begin : g_layout_err
    $error("segment parameters disagree with segment_pkg");
  end
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_OFFER = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;
  localparam logic [2:0] S_HALT = 3'd6;
  logic [2:0] state_q, state_d;
  logic [7:0] rec_state_q, rec_state_d, rec_state;
  motion_segment_t seg_q, seg_d, seg_unpacked;
  logic finished_q, finished_d, underrun_q, underrun_d, perr_q, perr_d;
  logic [31:0] done_q, done_d;
  logic xfer, latch, decoding, halt_clear, stray;
  segment_unpack #(.REC_W(RECORD_SIZE_BYTES * 8)) u_unpack (
    .record_i(fifo_record_i),
    .state_o (rec_state),
    .seg_o   (seg_unpacked)
  );
  always_comb begin
    xfer = state_q == S_OFFER && seg_ready_i;
    latch = state_q == S_WAIT && fifo_record_ready_i && !abort_i;
    decoding = state_q == S_DECODE && !abort_i;
    halt_clear = state_q == S_HALT && abort_i;
    stray = fifo_record_ready_i && state_q != S_WAIT && state_q != S_DRAIN;
    fifo_request_o = state_q == S_FETCH && fifo_available_i && !abort_i;
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = enable_i ? S_FETCH : S_IDLE;
      S_FETCH:  state_d = fifo_available_i ? S_WAIT : enable_i ? S_FETCH : S_IDLE;
      S_WAIT:   state_d = fifo_record_ready_i ? S_DECODE : S_WAIT;
      S_DECODE: state_d = rec_state_q == STATE_FILLED ? S_OFFER : S_HALT;
      S_OFFER:  state_d = !seg_ready_i ? S_OFFER : enable_i ? S_FETCH : S_IDLE;
      S_DRAIN:  state_d = fifo_record_ready_i ? S_IDLE : S_DRAIN;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
    // An outstanding request must still be drained before going idle.
    if (abort_i)
      state_d = (state_q == S_WAIT || state_q == S_DRAIN) && !fifo_record_ready_i ? S_DRAIN : S_IDLE;
    rec_state_d = latch ? rec_state : rec_state_q;
    seg_d = latch ? seg_unpacked : seg_q;
    finished_d = (finished_q && !halt_clear) || (decoding && rec_state_q == STATE_EXIT);
    perr_d = (perr_q && !halt_clear) || stray ||
             (decoding && rec_state_q != STATE_FILLED && rec_state_q != STATE_EXIT);
    underrun_d = underrun_q || (state_q == S_FETCH && enable_i && !fifo_available_i &&
                                !engine_busy_i && done_q != '0);
    done_d = xfer && done_q != '1 ? done_q + 32'd1 : done_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rec_state_q <= STATE_EMPTY;
      seg_q <= '0;
      finished_q <= 1'b0;
      underrun_q <= 1'b0;
      perr_q <= 1'b0;
      done_q <= '0;
    end else begin
      state_q <= state_d;
      rec_state_q <= rec_state_d;
      seg_q <= seg_d;
      finished_q <= finished_d;
      underrun_q <= underrun_d;
      perr_q <= perr_d;
      done_q <= done_d;
    end
  end
  assign seg_valid_o = state_q == S_OFFER;
  assign seg_data_o = seg_q;
  assign finished_o = finished_q;
  assign underrun_o = underrun_q;
  assign protocol_error_o = perr_q;
  assign segments_done_o = done_q;
endmodule

// File: tb/tb_segment_sequencer.sv
// tb_segment_sequencer: scoreboard bench; a Fifo model feeds records, a monitor checks offered segments.
module tb_segment_sequencer;
  logic clk = 1'b0;
  logic rst, enable, abort, fifo_available, fifo_request, fifo_record_ready;
  logic [431:0] fifo_record;
  logic seg_valid, seg_ready, engine_busy, finished, underrun, protocol_error;
  logic [423:0] seg_data;
  logic [31:0] segments_done;
  logic [431:0] rec_mem[$];
  logic [423:0] exp_q[$];
  int wr_cnt = 0, rd_ptr = 0, req_count = 0, cyc = 0, rdy_cyc = 0, lat = 0;
  int tests = 0, fails = 0, exp_done = 0, base = 0;
  logic hold_v = 1'b0, prev_valid = 1'b0, prev_xfer = 1'b0, prev_en = 1'b0, prev_abort = 1'b0;
  logic [423:0] hold_data = '0;
  logic [431:0] r;

  segment_sequencer dut (
    .clk(clk), .rst(rst), .enable_i(enable), .abort_i(abort),
    .fifo_available_i(fifo_available), .fifo_request_o(fifo_request),
    .fifo_record_ready_i(fifo_record_ready), .fifo_record_i(fifo_record),
    .seg_valid_o(seg_valid), .seg_ready_i(seg_ready), .seg_data_o(seg_data),
    .engine_busy_i(engine_busy), .finished_o(finished), .underrun_o(underrun),
    .protocol_error_o(protocol_error), .segments_done_o(segments_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign fifo_available = wr_cnt != rd_ptr;

  task automatic check(input string name, input logic [431:0] got, input logic [431:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Random record: state byte first, then every other field is arbitrary payload.
  function automatic logic [431:0] mk_rec(input logic [7:0] st);
    logic [431:0] x;
    for (int i = 0; i < 13; i++) x[i*32 +: 32] = $urandom;
    x[431:416] = 16'($urandom);
    x[7:0] = st;
    return x;
  endfunction

  task automatic push(input logic [431:0] rec, input bit want);
    rec_mem.push_back(rec);
    wr_cnt++;
    if (want) begin
      exp_q.push_back(rec[431:8]);
      exp_done++;
    end
  endtask

  always @(negedge clk) if (fifo_request === 1'b1) req_count <= req_count + 1;

  // Fifo model: answers each request with the next stored record after lat extra cycles.
  initial begin
    logic [431:0] rec;
    fifo_record_ready = 1'b0;
    fifo_record = '0;
    forever begin
      @(negedge clk);
      if (fifo_request === 1'b1) begin
        @(posedge clk);
        #1;
        rec = rd_ptr < rec_mem.size() ? rec_mem[rd_ptr] : '0;
        rd_ptr++;
        repeat (lat) begin
          @(posedge clk);
          #1;
        end
        fifo_record = rec;
        fifo_record_ready = 1'b1;
        rdy_cyc = cyc;
        @(posedge clk);
        #1;
        fifo_record_ready = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (hold_v && seg_valid) check("seg_data_stable", seg_data, hold_data);
      if (seg_valid && !prev_valid) check("offer_latency", cyc - rdy_cyc, 2);
      if (prev_xfer && prev_en && !prev_abort && fifo_available) check("req_after_xfer", fifo_request, 1);
      if (seg_valid && seg_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_xfer: got segment %0h, expected no transfer", seg_data);
        end else check("seg_data", seg_data, exp_q.pop_front());
      end
    end
    hold_v <= seg_valid && !seg_ready;
    hold_data <= seg_data;
    prev_valid <= seg_valid;
    prev_xfer <= seg_valid && seg_ready;
    prev_en <= enable;
    prev_abort <= abort;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; enable = 1'b1; abort = 1'b0; seg_ready = 1'b1; engine_busy = 1'b1;
    r = mk_rec(8'h01);
    r[47:32] = 16'h1234;
    r[431:400] = 32'hDEADBEEF;
    push(r, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rst_request", fifo_request, 0);
      check("rst_valid", seg_valid, 0);
      check("rst_flags", {finished, underrun, protocol_error}, 0);
      check("rst_done", segments_done, 0);
      check("rst_data", seg_data, 0);
    end
    check("rst_req_count", req_count, 0);
    rst = 1'b1;
    // single FILLED record
    for (int i = 0; i < 30 && segments_done != 1; i++) tick(1);
    check("t2_done", segments_done, 1);
    check("t2_loops_travel", seg_data[39:24], 16'h1234);
    check("t2_fraction7", seg_data[423:392], 32'hDEADBEEF);
    // three records with the engine stalling first
    seg_ready = 1'b0;
    lat = $urandom_range(0, 3);
    base = req_count;
    for (int i = 0; i < 3; i++) push(mk_rec(8'h01), 1'b1);
    for (int i = 0; i < 30 && !seg_valid; i++) tick(1);
    tick(5);
    check("t3_held_valid", seg_valid, 1);
    seg_ready = 1'b1;
    for (int i = 0; i < 60 && segments_done != exp_done; i++) tick(1);
    check("t3_done", segments_done, exp_done);
    check("t3_requests", req_count - base, 3);
    check("t3_no_underrun", underrun, 0);
    // starve the idle engine
    engine_busy = 1'b0;
    tick(3);
    check("t5_underrun", underrun, 1);
    engine_busy = 1'b1;
    push(mk_rec(8'h01), 1'b1);
    for (int i = 0; i < 30 && segments_done != exp_done; i++) tick(1);
    check("t5_resume_done", segments_done, exp_done);
    check("t5_underrun_sticky", underrun, 1);
    // abort while waiting for the record
    lat = 2;
    base = req_count;
    push(mk_rec(8'h01), 1'b0);
    for (int i = 0; i < 20 && req_count == base; i++) tick(1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(6);
    check("t6a_done", segments_done, exp_done);
    check("t6a_requests", req_count - base, 1);
    lat = 0;
    push(mk_rec(8'h01), 1'b1);
    for (int i = 0; i < 30 && segments_done != exp_done; i++) tick(1);
    check("t6a_after_done", segments_done, exp_done);
    // abort in the transfer cycle
    seg_ready = 1'b0;
    push(mk_rec(8'h01), 1'b1);
    for (int i = 0; i < 30 && !seg_valid; i++) tick(1);
    seg_ready = 1'b1;
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("t6b_valid_dropped", seg_valid, 0);
    check("t6b_done", segments_done, exp_done);
    // FILLED then EXIT
    lat = $urandom_range(0, 3);
    push(mk_rec(8'h01), 1'b1);
    push(mk_rec(8'h02), 1'b0);
    for (int i = 0; i < 60 && !finished; i++) tick(1);
    check("t4_finished", finished, 1);
    check("t4_done", segments_done, exp_done);
    base = req_count;
    r = mk_rec(8'h01);
    push(r, 1'b0);
    tick(10);
    check("t4_halt_no_request", req_count - base, 0);
    check("t4_halt_no_valid", seg_valid, 0);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("t4_finished_cleared", finished, 0);
    exp_q.push_back(r[431:8]);
    exp_done++;
    for (int i = 0; i < 30 && segments_done != exp_done; i++) tick(1);
    check("t4_restart_done", segments_done, exp_done);
    // bad state byte
    push(mk_rec(8'h07), 1'b0);
    for (int i = 0; i < 30 && !protocol_error; i++) tick(1);
    check("t5_protocol_error", protocol_error, 1);
    check("t5_no_valid", seg_valid, 0);
    check("t5_perr_done", segments_done, exp_done);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("t5_perr_cleared", protocol_error, 0);
    check("t5_underrun_kept", underrun, 1);
    // randomized stream
    for (int i = 0; i < 20; i++) push(mk_rec(8'h01), 1'b1);
    for (int i = 0; i < 3000 && segments_done != exp_done; i++) begin
      seg_ready = 1'($urandom_range(0, 1));
      enable = $urandom_range(0, 3) != 0;
      engine_busy = 1'($urandom_range(0, 1));
      lat = $urandom_range(0, 3);
      tick(1);
    end
    seg_ready = 1'b1;
    enable = 1'b1;
    check("rand_done", segments_done, exp_done);
    tick(2);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
